univ_shift_reg_p: RTL

Parametrised universal shift register, the next generation of the team's 4-bit select-driven register with parallel/serial in and out.
- Generalised to WIDTH bits, with arithmetic shift and multi-bit barrel shift/rotate by a runtime amount.
- Adds an autonomous serial burst engine (TX/RX) with busy/done status.
- Used as a serialiser/deserialiser and data-manipulation stage between parallel datapaths and 1-bit serial links.

---
 rtl/usr_pkg.sv | 21 ++
 rtl/usr_barrel.sv | 23 ++
 rtl/univ_shift_reg_p.sv | 80 ++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// usr_pkg: shared op codes, FSM states and serial-direction constants for univ_shift_reg_p
package usr_pkg;
   localparam logic [3:0] OP_HOLD     = 4'd0;
   localparam logic [3:0] OP_LOAD     = 4'd1;
   localparam logic [3:0] OP_SHL      = 4'd2;
   localparam logic [3:0] OP_SHR      = 4'd3;
   localparam logic [3:0] OP_ROL      = 4'd4;
   localparam logic [3:0] OP_ROR      = 4'd5;
   localparam logic [3:0] OP_ASR      = 4'd6;
   localparam logic [3:0] OP_SHL_N    = 4'd7;
   localparam logic [3:0] OP_SHR_N    = 4'd8;
   localparam logic [3:0] OP_ROL_N    = 4'd9;
   localparam logic [3:0] OP_ROR_N    = 4'd10;
   localparam logic [3:0] OP_CLEAR    = 4'd11;
   localparam logic [3:0] OP_BURST_TX = 4'd12;
   localparam logic [3:0] OP_BURST_RX = 4'd13;
   localparam logic DIR_L = 1'b0;
   localparam logic DIR_R = 1'b1;
   typedef enum logic [1:0] {ST_IDLE, ST_TX, ST_RX} state_t;
   typedef enum logic [1:0] {B_SHL, B_SHR, B_ROL, B_ROR} bop_t;
endpackage

// File: rtl/usr_barrel.sv
// usr_barrel: combinational shift/rotate by a runtime amount taken modulo WIDTH
module usr_barrel
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]   data,
   input  logic [SHAMT_W-1:0] shamt,
   input  bop_t               op,
   output logic [WIDTH-1:0]   result
);
   logic [31:0] amt;
   logic [WIDTH-1:0] l, r;
   // a zero amount makes the wrap-around term shift by WIDTH, which yields zero
   assign amt = 32'(shamt) % WIDTH;
   assign l = data << amt;
   assign r = data >> amt;
   assign result = op == B_SHL ? l :
                   op == B_SHR ? r :
                   op == B_ROL ? l | (data >> (WIDTH - amt)) :
                                 r | (data << (WIDTH - amt));
endmodule

// File: rtl/univ_shift_reg_p.sv
// univ_shift_reg_p: universal shift register with barrel ops and an autonomous serial burst engine
module univ_shift_reg_p
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [3:0]         sel,
   input  logic [WIDTH-1:0]   pin,
   input  logic               sin,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [WIDTH-1:0]   pout,
   output logic               sout,
   output logic               busy,
   output logic               done
);
   localparam logic [SHAMT_W:0] CNT_LAST = (SHAMT_W+1)'(WIDTH - 1);
   state_t st, st_n;
   logic [SHAMT_W:0] cnt, cnt_n;
   logic dir, dir_n, done_n;
   logic [WIDTH-1:0] pout_n, bres, shl, shr;
   bop_t bop;
   assign shl = {pout[WIDTH-2:0], sin};
   assign shr = {sin, pout[WIDTH-1:1]};
   assign bop = sel == OP_SHL_N ? B_SHL : sel == OP_SHR_N ? B_SHR : sel == OP_ROL_N ? B_ROL : B_ROR;
   assign busy = st != ST_IDLE;
   assign sout = dir == DIR_L ? pout[WIDTH-1] : pout[0];
   usr_barrel #(.WIDTH(WIDTH)) u_barrel (.data(pout), .shamt(shamt), .op(bop), .result(bres));
   always_comb begin
      pout_n = pout;
      dir_n  = dir;
      st_n   = st;
      cnt_n  = cnt;
      done_n = 1'b0;
      if (st == ST_IDLE) begin
         if (en) case (sel)
            OP_LOAD:            pout_n = pin;
            OP_SHL:             begin pout_n = shl; dir_n = DIR_L; end
            OP_SHR:             begin pout_n = shr; dir_n = DIR_R; end
            OP_ROL:             begin pout_n = {pout[WIDTH-2:0], pout[WIDTH-1]}; dir_n = DIR_L; end
            OP_ROR:             begin pout_n = {pout[0], pout[WIDTH-1:1]}; dir_n = DIR_R; end
            OP_ASR:             begin pout_n = {pout[WIDTH-1], pout[WIDTH-1:1]}; dir_n = DIR_R; end
            OP_SHL_N, OP_ROL_N: begin pout_n = bres; dir_n = DIR_L; end
            OP_SHR_N, OP_ROR_N: begin pout_n = bres; dir_n = DIR_R; end
            OP_CLEAR:           pout_n = '0;
            OP_BURST_TX:        begin st_n = ST_TX; cnt_n = '0; dir_n = DIR_L; end
            OP_BURST_RX:        begin st_n = ST_RX; cnt_n = '0; dir_n = DIR_R; end
            default:            ;
         endcase
      end else if (en && sel == OP_CLEAR) begin
         pout_n = '0;
         st_n   = ST_IDLE;
         cnt_n  = '0;
      end else begin
         pout_n = st == ST_TX ? shl : shr;
         cnt_n  = cnt + 1'b1;
         if (cnt == CNT_LAST) begin
            st_n   = ST_IDLE;
            done_n = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pout <= '0;
         dir  <= DIR_L;
         st   <= ST_IDLE;
         cnt  <= '0;
         done <= 1'b0;
      end else begin
         pout <= pout_n;
         dir  <= dir_n;
         st   <= st_n;
         cnt  <= cnt_n;
         done <= done_n;
      end
endmodule
